// File: rtl/gba_sound_pkg.sv
// gba_sound_pkg: shared defaults, register map and helpers for the Direct Sound FIFOs
package gba_sound_pkg;
   localparam int DEPTH_BYTES_DEF   = 32;
   localparam int REQ_THRESHOLD_DEF = 16;
   localparam logic [11:0] FIFO_A_ADDR = 12'h0A0;
   localparam logic [11:0] FIFO_B_ADDR = 12'h0A4;
   typedef enum logic {TIMER_SEL_0 = 1'b0, TIMER_SEL_1 = 1'b1} timer_sel_e;
   function automatic logic [7:0] lane_byte(input logic [31:0] w, input int k);
      return w[8*k +: 8];
   endfunction
endpackage

// File: rtl/gba_sound_fifo_push.sv
// gba_sound_fifo_push: compacts enabled byte lanes into an ordered list clipped by free space
module gba_sound_fifo_push
   import gba_sound_pkg::*;
#(
   parameter int CW = 6
) (
   input  logic           wr_en,
   input  logic [31:0]    wr_data,
   input  logic [3:0]     wr_be,
   input  logic [CW-1:0]  free,
   output logic [3:0][7:0] bytes,
   output logic [2:0]     accepted,
   output logic           drop
);
   // lane 0 first; lanes that no longer fit are dropped and flagged
   always_comb begin
      bytes    = '0;
      accepted = '0;
      drop     = 1'b0;
      for (int k = 0; k < 4; k++)
         if (wr_en && wr_be[k]) begin
            if (CW'(accepted) < free) begin
               bytes[accepted[1:0]] = lane_byte(wr_data, k);
               accepted = accepted + 3'd1;
            end else
               drop = 1'b1;
         end
   end
endmodule

// File: rtl/gba_sound_fifo.sv
// gba_sound_fifo: one Direct Sound channel byte FIFO with timer-driven pop and DMA refill request
module gba_sound_fifo
   import gba_sound_pkg::*;
#(
   parameter int DEPTH_BYTES   = DEPTH_BYTES_DEF,
   parameter int REQ_THRESHOLD = REQ_THRESHOLD_DEF
) (
   input  logic                          clk100,
   input  logic                          reset_n,
   input  logic                          ce,
   input  logic                          wr_en,
   input  logic [31:0]                   wr_data,
   input  logic [3:0]                    wr_be,
   input  logic                          fifo_clear,
   input  logic                          timer_tick,
   input  logic                          dma_enable,
   output logic [7:0]                    sample,
   output logic                          sample_valid,
   output logic                          sound_dma_req,
   output logic [$clog2(DEPTH_BYTES):0]  fifo_count,
   output logic                          overflow,
   output logic                          underflow
);
   localparam int AW = $clog2(DEPTH_BYTES);
   localparam int CW = AW + 1;
   logic [7:0]      mem [DEPTH_BYTES];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [3:0][7:0] push_bytes;
   logic [2:0]      push_n;
   logic            push_drop, push_en, clr, pop, pop_ok;
   logic [CW-1:0]   free, count_next;
   assign clr        = ce & fifo_clear;
   assign push_en    = ce & wr_en & ~fifo_clear;
   assign pop        = ce & timer_tick & dma_enable & ~fifo_clear;
   assign pop_ok     = pop & (fifo_count != '0);
   assign free       = CW'(DEPTH_BYTES) - fifo_count;
   assign count_next = fifo_count + CW'(push_n) - CW'(pop_ok);

   gba_sound_fifo_push #(.CW(CW)) u_push (
      .wr_en    (push_en),
      .wr_data  (wr_data),
      .wr_be    (wr_be),
      .free     (free),
      .bytes    (push_bytes),
      .accepted (push_n),
      .drop     (push_drop)
   );

   // byte storage; contents need no reset
   always_ff @(posedge clk100)
      for (int i = 0; i < 4; i++)
         if (3'(i) < push_n)
            mem[wr_ptr + AW'(i)] <= push_bytes[i];

   // pointers, level, sticky flags and the registered output pulses
   always_ff @(posedge clk100 or negedge reset_n)
      if (!reset_n) begin
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         fifo_count    <= '0;
         sample        <= '0;
         sample_valid  <= 1'b0;
         sound_dma_req <= 1'b0;
         overflow      <= 1'b0;
         underflow     <= 1'b0;
      end else if (clr) begin
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         fifo_count    <= '0;
         sample_valid  <= 1'b0;
         sound_dma_req <= 1'b0;
         overflow      <= 1'b0;
         underflow     <= 1'b0;
      end else begin
         wr_ptr        <= wr_ptr + AW'(push_n);
         rd_ptr        <= rd_ptr + AW'(pop_ok);
         fifo_count    <= count_next;
         sample        <= pop_ok ? mem[rd_ptr] : sample;
         sample_valid  <= pop_ok;
         sound_dma_req <= pop_ok && (count_next <= CW'(REQ_THRESHOLD));
         overflow      <= overflow | push_drop;
         underflow     <= underflow | (pop & ~pop_ok);
      end
endmodule

// File: doc/gba_sound_fifo.md
Name: gba_sound_fifo

Overview:
One Direct Sound channel FIFO (FIFO A or B) sitting directly upstream of gba_dma.
- Bus/DMA writes to the FIFO register push sample bytes in.
- The selected timer overflow pops one signed 8-bit sample per tick to the mixer.
- When the fill level falls to the refill threshold, it pulses sound_dma_req, which feeds gba_dma sound_dma_req[0] or [1].
- Two instances exist: one for FIFO A, one for FIFO B.

Parameters:
DEPTH_BYTES, 32, FIFO capacity in bytes (power of two, ≥8).
REQ_THRESHOLD, 16, request refill when the post-pop byte count is ≤ this value.

Ports:
clk100  input  1  system clock
reset_n  input  1  asynchronous active-low reset
ce  input  1  clock enable; all state advances only when ce=1
wr_en  input  1  one-cycle pulse: bus write to this channel's FIFO register
wr_data  input  32  write data; byte lane k = wr_data[8k+7:8k]
wr_be  input  4  byte enables of the write
fifo_clear  input  1  pulse from the SOUNDCNT_H FIFO-reset bit
timer_tick  input  1  pulse: overflow of the timer selected for this channel
dma_enable  input  1  channel enabled (either output side enabled in SOUNDCNT_H)
sample  output  8  current signed sample held for the mixer
sample_valid  output  1  one-cycle pulse when sample is updated
sound_dma_req  output  1  one-cycle refill request to gba_dma
fifo_count  output  6  bytes currently stored (0..DEPTH_BYTES)
overflow  output  1  sticky flag: a byte was dropped because the FIFO was full
underflow  output  1  sticky flag: a tick arrived while the FIFO was empty

Behaviour:
Reset (reset_n=0, asynchronous):
- Pointers = 0, count = 0, sample = 0.
- sample_valid = 0, sound_dma_req = 0, overflow = 0, underflow = 0.
- Storage contents are don't-care.

Storage and pointers:
- Circular byte array of DEPTH_BYTES entries.
- wr_ptr and rd_ptr are log2(DEPTH_BYTES) bits and wrap modulo DEPTH_BYTES.
- count is log2(DEPTH_BYTES)+1 bits.

Push (ce & wr_en):
- Enabled lanes are pushed in ascending order, lane 0 first.
- n = popcount(wr_be), 0..4 bytes in a single cycle.
- Bytes beyond free space (DEPTH_BYTES − count, evaluated before any same-cycle pop) are dropped, and overflow is set.
- Accepted bytes are written at wr_ptr, wr_ptr+1, ...; wr_ptr advances by the number accepted.

Pop (ce & timer_tick & dma_enable):
- If count > 0: sample ← mem[rd_ptr] and rd_ptr+1; sample_valid = 1 next cycle.
- If count = 0: sample is held, sample_valid stays 0, underflow is set.
- Ticks with dma_enable=0 are ignored entirely.

Simultaneous push and pop:
- The pop reads the oldest entry.
- count_next = count + accepted − popped.
- A pop from an empty FIFO cannot return a byte pushed in the same cycle; underflow is still flagged.

Refill request:
- sound_dma_req = 1 for exactly one cycle, the cycle after a successful pop whose count_next ≤ REQ_THRESHOLD.
- No request on a push alone, and none while dma_enable=0.
- Latency tick→req = 1 cycle, registered.

fifo_clear:
- Pointers and count → 0, overflow and underflow → 0.
- sample holds, and any pending req is suppressed.
- fifo_clear takes priority over a same-cycle push/pop; both are discarded.

ce=0: all registers hold; pulses are not generated.

Outputs are registered; no combinational input→output paths.

Decomposition:
- Shared package gba_sound_pkg: DEPTH_BYTES default, REQ_THRESHOLD default, FIFO register addresses (FIFO_A 0x0A0, FIFO_B 0x0A4), timer-select encoding.
- Natural sub-module: gba_sound_fifo_push — lane compaction, turning wr_be/wr_data into an ordered byte list plus count, clipped by free space.
- The top keeps pointers, count, flags and req.

Test Plan:
1. After reset, write word 0x44332211 (be=1111) then 4 ticks (dma_enable=1) → samples 0x11, 0x22, 0x33, 0x44 with one sample_valid each; count 4→0; sound_dma_req pulses after each pop.
2. Fill with 8 full-word writes (count=32), then tick 16 times → no req on pops 1–15 (count 31..17); req pulses once after pop 16 (count 16); req after each subsequent pop.
3. Count=30, write be=1111 → 2 bytes accepted, count=32, overflow=1; subsequent pops return the first two lanes only.
4. Empty FIFO with sample=0x7F, tick → sample stays 0x7F, no sample_valid, underflow=1, no req.
5. Count=10, same cycle: wr_en be=0011 and tick → count=11, sample = oldest byte. Separately, fifo_clear with a same-cycle write → count=0, flags cleared, the write is discarded.
6. Assert reset_n=0 mid-stream, asynchronously between edges → outputs are 0 immediately. Also: ticks with dma_enable=0 leave count unchanged, with no req.
